// File: rtl/sr_drive_ctrl_if.sv
// Request/command bundle between control logic, sr_drive_ctrl and the downstream SR flop.
// The master side raises requests and returns the flop's q; the slave side is the controller.
interface sr_drive_ctrl_if;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic s;
    logic r;
    logic busy;
    logic ack;
    logic conflict;
    logic state_err;

    modport master (
        output set_req, clr_req, q_fb,
        input  s, r, busy, ack, conflict, state_err
    );

    modport slave (
        input  set_req, clr_req, q_fb,
        output s, r, busy, ack, conflict, state_err
    );
endinterface

// File: rtl/sr_drive_ctrl.sv
// Turns level set/clear requests into legal one-cycle s/r pulses for an SR flop,
// verifies q afterwards, buffers one request and enforces a hold-off between commands.
module sr_drive_ctrl #(
    parameter int HOLDOFF    = 4,
    parameter bit PRIO_RESET = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    sr_drive_ctrl_if.slave bus
);

    localparam int   CW           = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic CONFLICT_TGT = ~PRIO_RESET;

    typedef enum logic [1:0] {IDLE, DRIVE, VERIFY, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tgt_q, tgt_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pend_tgt_q, pend_tgt_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic          conflict_q, conflict_d;
    logic          state_err_q, state_err_d;

    logic live_vld;
    logic live_both;
    logic live_tgt;
    logic cur_tgt;

    always_comb begin
        live_vld  = bus.set_req | bus.clr_req;
        live_both = bus.set_req & bus.clr_req;
        live_tgt  = live_both ? CONFLICT_TGT : bus.set_req;
        cur_tgt   = live_vld ? live_tgt : pend_tgt_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        pend_vld_d  = pend_vld_q;
        pend_tgt_d  = pend_tgt_q;
        s_d         = 1'b0;
        r_d         = 1'b0;
        ack_d       = 1'b0;
        conflict_d  = live_both;
        state_err_d = state_err_q;

        // Requests that arrive while a command is in flight overwrite the single buffer slot.
        if (state_q != IDLE && live_vld) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = live_tgt;
        end

        case (state_q)
            IDLE: begin
                if (live_vld || pend_vld_q) begin
                    pend_vld_d = 1'b0;
                    if (cur_tgt == bus.q_fb) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d = DRIVE;
                        tgt_d   = cur_tgt;
                        s_d     = cur_tgt;
                        r_d     = ~cur_tgt;
                    end
                end
            end
            DRIVE: begin
                state_d = VERIFY;
            end
            VERIFY: begin
                ack_d = 1'b1;
                if (bus.q_fb != tgt_q) begin
                    state_err_d = 1'b1;
                end
                if (HOLDOFF == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLDOFF);
                end
            end
            HOLD: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tgt_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_tgt_q  <= 1'b0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            conflict_q  <= 1'b0;
            state_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            pend_vld_q  <= pend_vld_d;
            pend_tgt_q  <= pend_tgt_d;
            s_q         <= s_d;
            r_q         <= r_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            conflict_q  <= conflict_d;
            state_err_q <= state_err_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;
    assign bus.conflict  = conflict_q;
    assign bus.state_err = state_err_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl: instance A uses defaults, instance B uses HOLDOFF=0, set-wins.
// Each ack is matched against the command kind queued when its request was driven.
module tb_sr_drive_ctrl;

    localparam int P_NONE = 0;
    localparam int P_SET  = 1;
    localparam int P_CLR  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_drive_ctrl_if ifa ();
    sr_drive_ctrl_if ifb ();

    logic tie_en  = 1'b0;
    logic tie_val = 1'b0;
    logic flop_a  = 1'b0;
    logic flop_b  = 1'b0;

    int checks     = 0;
    int failures   = 0;
    int exp_q[$];
    int last_pulse = P_NONE;
    int exp_kind;

    sr_drive_ctrl dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    sr_drive_ctrl #(.HOLDOFF(0), .PRIO_RESET(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Behavioural SR flops downstream of each controller; A's can be overridden by a tie.
    assign ifa.q_fb = tie_en ? tie_val : flop_a;
    assign ifb.q_fb = flop_b;

    always @(posedge clk) begin
        if (!tie_en) begin
            if (ifa.s)      flop_a <= 1'b1;
            else if (ifa.r) flop_a <= 1'b0;
        end
        if (ifb.s)      flop_b <= 1'b1;
        else if (ifb.r) flop_b <= 1'b0;
    end

    // Scoreboard side: remember the last pulse and match it against the queue on every ack.
    always @(negedge clk) begin
        if (rst) begin
            last_pulse = P_NONE;
        end else begin
            checks++;
            assert (!(ifa.s && ifa.r)) else begin
                failures++;
                $error("[TB] FAIL s_r_exclusive: s=%b r=%b required not both 1", ifa.s, ifa.r);
            end
            if (ifa.s)      last_pulse = P_SET;
            else if (ifa.r) last_pulse = P_CLR;
            if (ifa.ack) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("[TB] FAIL unexpected_ack: ack=1 with %0d queued commands, required queued >= 1", exp_q.size());
                end
                if (exp_q.size() != 0) begin
                    exp_kind = exp_q.pop_front();
                    checks++;
                    assert (last_pulse === exp_kind) else begin
                        failures++;
                        $error("[TB] FAIL ack_kind: pulse kind=%0d required %0d", last_pulse, exp_kind);
                    end
                end
                last_pulse = P_NONE;
            end
        end
    end

    function automatic logic [5:0] outsA();
        return {ifa.s, ifa.r, ifa.busy, ifa.ack, ifa.conflict, ifa.state_err};
    endfunction

    function automatic logic [5:0] outsB();
        return {ifb.s, ifb.r, ifb.busy, ifb.ack, ifb.conflict, ifb.state_err};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic set, input logic clr);
        ifa.set_req = set;
        ifa.clr_req = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("[TB] FAIL %s: {s,r,busy,ack,conflict,err}=%b required %b", tag, act, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("[TB] FAIL %s: value=%b required %b", tag, act, exp);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0);
        ifb.set_req = 1'b0;
        ifb.clr_req = 1'b0;
        step(2);
        checkOutput("reset_a", outsA(), 6'b000000);
        checkOutput("reset_b", outsB(), 6'b000000);
        rst = 1'b0;

        $display("[TB] set from q=0");
        applyStimulus(1'b1, 1'b0); exp_q.push_back(P_SET);
        step(1); applyStimulus(1'b0, 1'b0);
        checkOutput("t1_drive", outsA(), 6'b101000);
        step(1); checkOutput("t1_verify", outsA(), 6'b001000);
        step(1); checkOutput("t1_ack", outsA(), 6'b001100);
        step(3); checkOutput("t1_hold_end", outsA(), 6'b001000);
        step(1); checkOutput("t1_idle", outsA(), 6'b000000);
        checkBit("t1_qfb", ifa.q_fb, 1'b1);

        $display("[TB] clear from q=1");
        applyStimulus(1'b0, 1'b1); exp_q.push_back(P_CLR);
        step(1); applyStimulus(1'b0, 1'b0);
        checkOutput("t2_drive", outsA(), 6'b011000);
        step(1); checkOutput("t2_verify", outsA(), 6'b001000);
        step(1); checkOutput("t2_ack", outsA(), 6'b001100);
        checkBit("t2_qfb", ifa.q_fb, 1'b0);
        step(4); checkOutput("t2_idle", outsA(), 6'b000000);

        $display("[TB] conflict, clear wins");
        applyStimulus(1'b1, 1'b0); exp_q.push_back(P_SET);
        step(1); applyStimulus(1'b0, 1'b0);
        step(6); checkOutput("t3_pre_idle", outsA(), 6'b000000);
        checkBit("t3_pre_qfb", ifa.q_fb, 1'b1);
        applyStimulus(1'b1, 1'b1); exp_q.push_back(P_CLR);
        step(1); applyStimulus(1'b0, 1'b0);
        checkOutput("t3_conflict", outsA(), 6'b011010);
        step(1); checkOutput("t3_after", outsA(), 6'b001000);
        step(1); checkOutput("t3_ack", outsA(), 6'b001100);
        step(4); checkOutput("t3_idle", outsA(), 6'b000000);

        $display("[TB] pending buffer, last request wins");
        applyStimulus(1'b1, 1'b0); exp_q.push_back(P_SET);
        step(1); applyStimulus(1'b0, 1'b0);
        checkOutput("t4_drive", outsA(), 6'b101000);
        step(2); checkOutput("t4_ack", outsA(), 6'b001100);
        applyStimulus(1'b1, 1'b0);
        step(1); applyStimulus(1'b0, 1'b1); exp_q.push_back(P_CLR);
        step(1); applyStimulus(1'b0, 1'b0);
        step(2); checkOutput("t4_idle_gap", outsA(), 6'b000000);
        step(1); checkOutput("t4_pend_clr", outsA(), 6'b011000);
        step(2); checkOutput("t4_pend_ack", outsA(), 6'b001100);
        step(4); checkOutput("t4_idle", outsA(), 6'b000000);
        step(3); checkBit("t4_queue_empty", exp_q.size() == 0, 1'b1);

        $display("[TB] stuck q_fb sets sticky error");
        tie_en = 1'b1; tie_val = 1'b0;
        applyStimulus(1'b1, 1'b0); exp_q.push_back(P_SET);
        step(1); applyStimulus(1'b0, 1'b0);
        checkOutput("t5_drive", outsA(), 6'b101000);
        step(2); checkOutput("t5_err", outsA(), 6'b001101);
        step(4); checkOutput("t5_idle", outsA(), 6'b000001);
        applyStimulus(1'b0, 1'b1); exp_q.push_back(P_NONE);
        step(1); applyStimulus(1'b0, 1'b0);
        checkOutput("t5_redundant", outsA(), 6'b000101);
        step(1); checkOutput("t5_sticky", outsA(), 6'b000001);

        $display("[TB] reset during DRIVE");
        tie_en = 1'b0;
        applyStimulus(1'b1, 1'b0); exp_q.push_back(P_SET);
        step(1); applyStimulus(1'b0, 1'b0);
        checkOutput("t6_drive", outsA(), 6'b101001);
        #1 rst = 1'b1;
        #1 checkOutput("t6_async_reset", outsA(), 6'b000000);
        exp_q.delete();
        step(2); rst = 1'b0;
        step(5); checkOutput("t6_after", outsA(), 6'b000000);
        checkBit("t6_queue_empty", exp_q.size() == 0, 1'b1);

        $display("[TB] instance B: set wins, no hold-off");
        ifb.set_req = 1'b1; ifb.clr_req = 1'b1;
        step(1); ifb.set_req = 1'b0; ifb.clr_req = 1'b0;
        checkOutput("b_conflict", outsB(), 6'b101010);
        step(1); checkOutput("b_verify", outsB(), 6'b001000);
        step(1); checkOutput("b_ack_idle", outsB(), 6'b000100);
        checkBit("b_qfb", ifb.q_fb, 1'b1);
        step(1); checkOutput("b_quiet", outsB(), 6'b000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
